wb_stage: RTL and testbench

- Writeback and flag-register stage directly downstream of the ALU in the 16-bit multi-cycle core.
- Registers each ALU result and writes it to the register file, or writes load data from memory.
- Issues PC loads for branches and drives the output port for OUT.
- Holds the architectural S/Z/C/V flags, which feed back to the ALU's S_in/Z_in/C_in/V_in.
- Latches HLT.

---
 rtl/wb_stage.sv | 202 ++++++++++++++++++++
 tb/tb_wb_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback/flag stage: registers ALU results into the regfile, PC, OUT port and S/Z/C/V flags; latency 1.
// Backpressure: ready_out low while waiting on load data or halted; offers presented then are dropped.
module wb_stage #(
  parameter int WIDTH   = 16,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               s_in,
  input  logic               z_in,
  input  logic               c_in,
  input  logic               v_in,
  input  logic               hlt_in,
  input  logic [1:0]         op1,
  input  logic [2:0]         op2,
  input  logic [3:0]         opcode,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               mem_rvalid,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic               reg_we,
  output logic [RADDR_W-1:0] reg_waddr,
  output logic [WIDTH-1:0]   reg_wdata,
  output logic               pc_load,
  output logic [WIDTH-1:0]   pc_target,
  output logic               s_q,
  output logic               z_q,
  output logic               c_q,
  output logic               v_q,
  output logic [WIDTH-1:0]   out_port,
  output logic               out_valid,
  output logic               halted
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    HALT     = 2'd2
  } state_t;

  typedef struct packed {
    logic wr;
    logic flg;
    logic out;
    logic br;
    logic ld;
    logic hlt;
  } act_t;

  state_t               state_q, state_d;
  act_t                 act;
  logic                 accept;
  logic [3:0]           flags_q, flags_d;
  logic [RADDR_W-1:0]   ld_addr_q, ld_addr_d;

  logic                 reg_we_d;
  logic [RADDR_W-1:0]   reg_waddr_d;
  logic [WIDTH-1:0]     reg_wdata_d;
  logic                 pc_load_d;
  logic [WIDTH-1:0]     pc_target_d;
  logic [WIDTH-1:0]     out_port_d;
  logic                 out_valid_d;
  logic                 halted_d;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign ready_out = rst_n & (state_q == RUN);
  assign accept    = valid_in & ready_out;

  assign s_q = flags_q[3];
  assign z_q = flags_q[2];
  assign c_q = flags_q[1];
  assign v_q = flags_q[0];

  // Instruction decode into the set of side effects an accepted op has.
  always_comb begin
    act = '0;
    if (hlt_in) begin
      act.hlt = 1'b1;
    end else begin
      unique case (op1)
        2'b11: begin
          case (opcode)
            4'd5:       act.flg = 1'b1;
            4'd7, 4'd14: ;
            4'd12:      act.wr  = 1'b1;
            4'd13:      act.out = 1'b1;
            4'd15:      act.hlt = 1'b1;
            default: begin
              act.wr  = 1'b1;
              act.flg = 1'b1;
            end
          endcase
        end
        2'b00: act.ld = 1'b1;
        2'b01: ;
        2'b10: begin
          case (op2)
            3'b000:         act.wr = 1'b1;
            3'b100, 3'b111: act.br = 1'b1;
            default: ;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          if (act.hlt)     state_d = HALT;
          else if (act.ld) state_d = WAIT_MEM;
        end
      end
      WAIT_MEM: if (mem_rvalid) state_d = RUN;
      HALT:     state_d = HALT;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    reg_we_d    = 1'b0;
    reg_waddr_d = reg_waddr;
    reg_wdata_d = reg_wdata;
    pc_load_d   = 1'b0;
    pc_target_d = pc_target;
    out_port_d  = out_port;
    out_valid_d = 1'b0;
    halted_d    = halted;
    flags_d     = flags_q;
    ld_addr_d   = ld_addr_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          if (act.wr) begin
            reg_we_d    = 1'b1;
            reg_waddr_d = rd_addr;
            reg_wdata_d = alu_out;
          end
          if (act.flg) flags_d = {s_in, z_in, c_in, v_in};
          if (act.out) begin
            out_port_d  = alu_out;
            out_valid_d = 1'b1;
          end
          if (act.br) begin
            pc_load_d   = 1'b1;
            pc_target_d = alu_out;
          end
          if (act.ld)  ld_addr_d = rd_addr;
          if (act.hlt) halted_d  = 1'b1;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          reg_we_d    = 1'b1;
          reg_waddr_d = ld_addr_q;
          reg_wdata_d = mem_rdata;
        end
      end
      HALT:    halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      out_port  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      flags_q   <= '0;
      ld_addr_q <= '0;
    end else begin
      reg_we    <= reg_we_d;
      reg_waddr <= reg_waddr_d;
      reg_wdata <= reg_wdata_d;
      pc_load   <= pc_load_d;
      pc_target <= pc_target_d;
      out_port  <= out_port_d;
      out_valid <= out_valid_d;
      halted    <= halted_d;
      flags_q   <= flags_d;
      ld_addr_q <= ld_addr_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed expectations for each instruction class, stalls, halt and reset.
module tb_wb_stage;
  localparam int W  = 16;
  localparam int RA = 3;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic          ready_out;
  logic [W-1:0]  alu_out;
  logic          s_in, z_in, c_in, v_in;
  logic          hlt_in;
  logic [1:0]    op1;
  logic [2:0]    op2;
  logic [3:0]    opcode;
  logic [RA-1:0] rd_addr;
  logic          mem_rvalid;
  logic [W-1:0]  mem_rdata;
  logic          reg_we;
  logic [RA-1:0] reg_waddr;
  logic [W-1:0]  reg_wdata;
  logic          pc_load;
  logic [W-1:0]  pc_target;
  logic          s_q, z_q, c_q, v_q;
  logic [W-1:0]  out_port;
  logic          out_valid;
  logic          halted;
  logic [3:0]    flg;

  int n_chk  = 0;
  int n_fail = 0;
  int lo;

  assign flg = {s_q, z_q, c_q, v_q};

  wb_stage #(.WIDTH(W), .RADDR_W(RA)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .alu_out(alu_out), .s_in(s_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
    .hlt_in(hlt_in), .op1(op1), .op2(op2), .opcode(opcode), .rd_addr(rd_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .pc_load(pc_load), .pc_target(pc_target),
    .s_q(s_q), .z_q(z_q), .c_q(c_q), .v_q(v_q),
    .out_port(out_port), .out_valid(out_valid), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o1, input logic [2:0] o2, input logic [3:0] oc,
                       input logic [RA-1:0] rd, input logic [W-1:0] alu,
                       input logic [3:0] f, input logic h);
    @(negedge clk);
    op1 = o1; op2 = o2; opcode = oc; rd_addr = rd; alu_out = alu;
    {s_in, z_in, c_in, v_in} = f;
    hlt_in = h;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    hlt_in = 1'b0;
  endtask

  task automatic issue_alu(input logic [3:0] oc, input logic [RA-1:0] rd,
                           input logic [W-1:0] alu, input logic [3:0] f);
    issue(2'b11, 3'b000, oc, rd, alu, f, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; valid_in = 1'b0; alu_out = '0; {s_in, z_in, c_in, v_in} = 4'b0;
    hlt_in = 1'b0; op1 = '0; op2 = '0; opcode = '0; rd_addr = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset asserted mid-cycle takes effect immediately
    @(posedge clk); #3 rst_n = 1'b0; #1;
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_out_port", out_port, 0);
    chk("rst_flags", flg, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ready", ready_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rel_ready", ready_out, 1);

    // ADD with Z and C set
    issue_alu(4'd0, 3'd3, 16'h0000, 4'b0110);
    chk("add_we", reg_we, 1);
    chk("add_waddr", reg_waddr, 3);
    chk("add_wdata", reg_wdata, 16'h0000);
    chk("add_flags", flg, 4'b0110);
    // MOV clears flags from its own flag inputs
    issue_alu(4'd1, 3'd2, 16'h5555, 4'b0000);
    chk("mov_we", reg_we, 1);
    chk("mov_wdata", reg_wdata, 16'h5555);
    chk("mov_flags", flg, 4'b0000);
    // IN writes but leaves flags alone
    issue_alu(4'd12, 3'd7, 16'h0C0C, 4'b1111);
    chk("in_we", reg_we, 1);
    chk("in_waddr", reg_waddr, 7);
    chk("in_flags", flg, 4'b0000);

    // CMP then OUT
    issue_alu(4'd5, 3'd4, 16'h7777, 4'b1000);
    chk("cmp_we", reg_we, 0);
    chk("cmp_flags", flg, 4'b1000);
    issue_alu(4'd13, 3'd0, 16'hBEEF, 4'b0100);
    chk("out_port", out_port, 16'hBEEF);
    chk("out_valid", out_valid, 1);
    chk("out_we", reg_we, 0);
    chk("out_flags", flg, 4'b1000);
    step();
    chk("out_valid_drop", out_valid, 0);
    chk("out_port_hold", out_port, 16'hBEEF);

    // LD with a 3-cycle stall and an ignored offer during the stall
    issue(2'b00, 3'b000, 4'd0, 3'd5, 16'h0100, 4'b0000, 1'b0);
    lo = 0;
    if (!ready_out) lo++;
    chk("ld_we0", reg_we, 0);
    @(negedge clk);
    op1 = 2'b11; opcode = 4'd0; rd_addr = 3'd6; alu_out = 16'hDEAD;
    {s_in, z_in, c_in, v_in} = 4'b1111; valid_in = 1'b1; mem_rvalid = 1'b1 ^ 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (!ready_out) lo++;
      chk("stall_we", reg_we, 0);
    end
    @(negedge clk);
    valid_in = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_rvalid = 1'b0;
    chk("ld_ready_lo_cycles", lo, 4);
    chk("ld_we", reg_we, 1);
    chk("ld_waddr", reg_waddr, 5);
    chk("ld_wdata", reg_wdata, 16'h1234);
    chk("ld_ready", ready_out, 1);
    chk("ld_flags", flg, 4'b1000);
    step();
    chk("ld_we_drop", reg_we, 0);

    // Branches and LI
    issue(2'b10, 3'b111, 4'd0, 3'd0, 16'h0040, 4'b1111, 1'b0);
    chk("bcc_pc_load", pc_load, 1);
    chk("bcc_target", pc_target, 16'h0040);
    chk("bcc_we", reg_we, 0);
    chk("bcc_flags", flg, 4'b1000);
    step();
    chk("bcc_pc_drop", pc_load, 0);
    chk("bcc_target_hold", pc_target, 16'h0040);
    issue(2'b10, 3'b000, 4'd0, 3'd1, 16'h00AA, 4'b0000, 1'b0);
    chk("li_we", reg_we, 1);
    chk("li_waddr", reg_waddr, 1);
    chk("li_wdata", reg_wdata, 16'h00AA);
    chk("li_pc_load", pc_load, 0);
    issue(2'b10, 3'b100, 4'd0, 3'd0, 16'h0080, 4'b0000, 1'b0);
    chk("b_pc_load", pc_load, 1);
    chk("b_target", pc_target, 16'h0080);
    issue(2'b10, 3'b010, 4'd0, 3'd2, 16'h0999, 4'b0000, 1'b0);
    chk("op2_other_pc", pc_load, 0);
    chk("op2_other_we", reg_we, 0);
    issue(2'b01, 3'b000, 4'd0, 3'd2, 16'h0999, 4'b0000, 1'b0);
    chk("st_we", reg_we, 0);
    issue_alu(4'd7, 3'd2, 16'h0999, 4'b0111);
    chk("nop_we", reg_we, 0);
    chk("nop_flags", flg, 4'b1000);

    // HLT opcode
    issue_alu(4'd15, 3'd2, 16'h1111, 4'b1111);
    chk("hlt_halted", halted, 1);
    chk("hlt_ready", ready_out, 0);
    chk("hlt_we", reg_we, 0);
    chk("hlt_flags", flg, 4'b1000);
    issue_alu(4'd0, 3'd3, 16'h2222, 4'b0101);
    chk("halt_add_we", reg_we, 0);
    chk("halt_add_flags", flg, 4'b1000);
    step();
    chk("halt_sticky", halted, 1);
    chk("halt_out_port", out_port, 16'hBEEF);

    // Reset pulse clears halt
    #2 rst_n = 1'b0; #1;
    chk("rst2_halted", halted, 0);
    chk("rst2_flags", flg, 0);
    chk("rst2_out_port", out_port, 0);
    chk("rst2_pc_target", pc_target, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst2_ready", ready_out, 1);

    // Reset while waiting on load data discards the load
    issue(2'b00, 3'b000, 4'd0, 3'd4, 16'h0200, 4'b0000, 1'b0);
    chk("ld2_ready", ready_out, 0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h9999;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ld2_discard_we", reg_we, 0);
    end
    mem_rvalid = 1'b0;
    chk("ld2_ready_after", ready_out, 1);

    // hlt_in overrides a flag-setting ADD
    issue(2'b11, 3'b000, 4'd0, 3'd2, 16'h3333, 4'b1111, 1'b1);
    chk("hltin_halted", halted, 1);
    chk("hltin_we", reg_we, 0);
    chk("hltin_flags", flg, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
